// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave state type and byte-lane strobe helper.
package ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Byte lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SIZE_BYTE: m = 4'b0001 << a;
      SIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_mem_slave_if.sv
// AHB bus signals between a master (or bus matrix) and the memory slave.
interface ahb_mem_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_mem_core.sv
// Word-organised memory array: byte-enabled synchronous write, asynchronous read.
module ahb_mem_core #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [3:0]            be_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];

  // Commit only the enabled byte lanes; the rest of the word keeps its value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

  // Backdoor read for benches; bypasses the bus entirely.
  function automatic logic [31:0] bd_read(input int unsigned idx);
    return mem_q[idx[DEPTH_LOG2-1:0]];
  endfunction

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB memory slave: address capture, legality check, wait-state FSM and
// two-cycle ERROR response around a byte-lane memory core.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input logic            HCLK,
  input logic            HRESET,
  ahb_mem_slave_if.slave bus
);

  localparam int AW = DEPTH_LOG2 + 2;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic          legal_q;

  logic          accept;
  logic          capture;
  logic          legal;
  logic [3:0]    wr_be;
  logic [31:0]   rdata;
  logic          unused_bus;

  // Burst type and the SEQ/NONSEQ distinction carry no meaning here.
  assign unused_bus = ^{bus.HBURST, bus.HTRANS[0]};

  // A new address phase can only land while this slave reports ready.
  assign accept  = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign capture = accept && bus.HSEL && bus.HREADY && bus.HTRANS[1];

  // Legality of the access currently on the address bus.
  always_comb begin
    legal = 1'b1;
    if (bus.HSIZE > SIZE_WORD) legal = 1'b0;
    if ((bus.HSIZE == SIZE_HALF) && bus.HADDR[0]) legal = 1'b0;
    if ((bus.HSIZE == SIZE_WORD) && (bus.HADDR[1:0] != 2'b00)) legal = 1'b0;
    if ((bus.HADDR >> AW) != 32'd0) legal = 1'b0;
  end

  // State and wait counter; reset abandons any transfer in flight.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address/control registers for the pending data phase.
  always_ff @(posedge HCLK) begin
    if (capture) begin
      addr_q  <= bus.HADDR[AW-1:0];
      write_q <= bus.HWRITE;
      size_q  <= bus.HSIZE;
      legal_q <= legal;
    end
  end

  // Next-state: ready states may take a new beat; WAIT counts down; ERR1 always moves on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_DATA;
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        if (capture) begin
          if (!legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // Outputs depend only on registered state, never on the live address phase.
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = RESP_OKAY;
    bus.HRDATA    = 32'd0;
    case (state_q)
      ST_WAIT: bus.HREADYOUT = 1'b0;
      ST_DATA: bus.HRDATA    = rdata;
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = RESP_ERROR;
      end
      ST_ERR2: bus.HRESP = RESP_ERROR;
      default: ;
    endcase
  end

  // Writes commit at the end of the DATA cycle, so a following read sees them.
  assign wr_be = ((state_q == ST_DATA) && write_q && legal_q && !HRESET)
                 ? byte_strobe(size_q, addr_q[1:0]) : 4'b0000;

  ahb_mem_core #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_core (
    .clk     (HCLK),
    .be_i    (wr_be),
    .addr_i  (addr_q[AW-1:2]),
    .wdata_i (bus.HWDATA),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave with three wait-state configurations.
module tb_ahb_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  int          dsel;

  int checks = 0;
  int errors = 0;

  ahb_mem_slave_if if0 ();
  ahb_mem_slave_if if1 ();
  ahb_mem_slave_if if2 ();

  assign if0.HSEL = hsel && (dsel == 0);
  assign if1.HSEL = hsel && (dsel == 1);
  assign if2.HSEL = hsel && (dsel == 2);
  assign if0.HADDR = haddr;   assign if1.HADDR = haddr;   assign if2.HADDR = haddr;
  assign if0.HTRANS = htrans; assign if1.HTRANS = htrans; assign if2.HTRANS = htrans;
  assign if0.HWRITE = hwrite; assign if1.HWRITE = hwrite; assign if2.HWRITE = hwrite;
  assign if0.HSIZE = hsize;   assign if1.HSIZE = hsize;   assign if2.HSIZE = hsize;
  assign if0.HBURST = hburst; assign if1.HBURST = hburst; assign if2.HBURST = hburst;
  assign if0.HWDATA = hwdata; assign if1.HWDATA = hwdata; assign if2.HWDATA = hwdata;
  assign if0.HREADY = if0.HREADYOUT;
  assign if1.HREADY = if1.HREADYOUT;
  assign if2.HREADY = if2.HREADYOUT;

  ahb_mem_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_d0 (.HCLK(clk), .HRESET(hreset), .bus(if0));
  ahb_mem_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_d1 (.HCLK(clk), .HRESET(hreset), .bus(if1));
  ahb_mem_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(5)) u_d2 (.HCLK(clk), .HRESET(hreset), .bus(if2));

  logic        rdy;
  logic [1:0]  rsp;
  logic [31:0] rdt;

  always_comb begin
    rdy = if0.HREADYOUT;
    rsp = if0.HRESP;
    rdt = if0.HRDATA;
    case (dsel)
      1: begin rdy = if1.HREADYOUT; rsp = if1.HRESP; rdt = if1.HRDATA; end
      2: begin rdy = if2.HREADYOUT; rsp = if2.HRESP; rdt = if2.HRDATA; end
      default: ;
    endcase
  end

  int          t_lows;
  logic [1:0]  t_resp0;
  logic [1:0]  t_resp;
  logic [31:0] t_rdata;
  logic [31:0] pre [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single non-pipelined transfer; records response and stall count.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    int n;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size; hburst = 3'b000;
    tick();
    htrans = 2'b00; hwdata = wdata; n = 0;
    t_resp0 = rsp;
    while (!rdy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 40) else begin
      errors++;
      $error("FAIL xfer_timeout observed=%0d expected=<40", n);
    end
    t_lows = n; t_resp = rsp; t_rdata = rdt;
    tick();
  endtask

  initial begin
    pre[0] = 32'hCAFE0100; pre[1] = 32'hCAFE0104;
    pre[2] = 32'hCAFE0108; pre[3] = 32'hCAFE010C;
    hreset = 1'b1; hsel = 1'b0; haddr = 32'd0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hwdata = 32'd0; dsel = 0;
    tick(); tick(); tick();
    hreset = 1'b0;
    tick();

    // reset state of all three slaves
    for (int d = 0; d < 3; d++) begin
      dsel = d;
      #1;
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_resp", 32'(rsp), 32'd0);
      chk("rst_rdata", rdt, 32'd0);
    end

    // word write then back-to-back read, zero wait
    dsel = 0;
    hsel = 1'b1; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10; htrans = 2'b10;
    tick();
    chk("t1_wr_ready", 32'(rdy), 32'd1);
    hwdata = 32'hA5A5_1234; hwrite = 1'b0; haddr = 32'h10; htrans = 2'b10;
    tick();
    htrans = 2'b00;
    chk("t1_rd_ready", 32'(rdy), 32'd1);
    chk("t1_rd_resp", 32'(rsp), 32'd0);
    chk("t1_rd_data", rdt, 32'hA5A5_1234);
    tick();
    chk("t1_backdoor", u_d0.u_core.bd_read(32'h4), 32'hA5A5_1234);

    // byte and halfword merge into an existing word
    xfer(1'b1, 32'h20, 3'd2, 32'h0403_0201);
    xfer(1'b1, 32'h21, 3'd0, 32'h0000_FF00);
    xfer(1'b1, 32'h22, 3'd1, 32'hBEEF_0000);
    xfer(1'b0, 32'h20, 3'd2, 32'h0);
    chk("t2_merge_data", t_rdata, 32'hBEEF_FF01);
    chk("t2_merge_lows", 32'(t_lows), 32'd0);

    // wait states: preload then INCR4 read burst
    dsel = 1;
    for (int i = 0; i < 4; i++) xfer(1'b1, 32'h100 + 32'(4 * i), 3'd2, pre[i]);
    chk("t3_preload_lows", 32'(t_lows), 32'd3);
    chk("t3_backdoor", u_d1.u_core.bd_read(32'h42), 32'hCAFE0108);
    hsel = 1'b1; hwrite = 1'b0; hsize = 3'd2; hburst = 3'b011; haddr = 32'h100; htrans = 2'b10;
    tick();
    for (int i = 0; i < 4; i++) begin
      int n;
      if (i < 3) begin
        htrans = 2'b11; haddr = 32'h100 + 32'(4 * (i + 1));
      end else begin
        htrans = 2'b00;
      end
      n = 0;
      while (!rdy && n < 40) begin
        tick();
        n++;
      end
      chk("t3_beat_lows", 32'(n), 32'd3);
      chk("t3_beat_data", rdt, pre[i]);
      chk("t3_beat_resp", 32'(rsp), 32'd0);
      tick();
    end

    // illegal accesses: misaligned word, bad size, out of range
    xfer(1'b1, 32'h102, 3'd2, 32'hDEAD_BEEF);
    chk("t4_mis_resp0", 32'(t_resp0), 32'd1);
    chk("t4_mis_lows", 32'(t_lows), 32'd1);
    chk("t4_mis_resp1", 32'(t_resp), 32'd1);
    chk("t4_mis_mem", u_d1.u_core.bd_read(32'h40), 32'hCAFE0100);
    xfer(1'b1, 32'h104, 3'd3, 32'hDEAD_BEEF);
    chk("t4_size_resp0", 32'(t_resp0), 32'd1);
    chk("t4_size_lows", 32'(t_lows), 32'd1);
    chk("t4_size_resp1", 32'(t_resp), 32'd1);
    chk("t4_size_mem", u_d1.u_core.bd_read(32'h41), 32'hCAFE0104);
    dsel = 0;
    xfer(1'b1, 32'h0, 3'd2, 32'h1357_2468);
    xfer(1'b1, 32'h0001_0000, 3'd2, 32'hDEAD_BEEF);
    chk("t4_range_resp0", 32'(t_resp0), 32'd1);
    chk("t4_range_lows", 32'(t_lows), 32'd1);
    chk("t4_range_resp1", 32'(t_resp), 32'd1);
    chk("t4_range_mem", u_d0.u_core.bd_read(32'h0), 32'h1357_2468);
    xfer(1'b0, 32'h0, 3'd2, 32'h0);
    chk("t4_after_err_read", t_rdata, 32'h1357_2468);
    chk("t4_after_err_resp", 32'(t_resp), 32'd0);

    // INCR4 write with BUSY after beat 2
    hsel = 1'b1; hwrite = 1'b1; hsize = 3'd2; hburst = 3'b011;
    haddr = 32'h200; htrans = 2'b10;
    tick();
    hwdata = 32'h1111_0000; haddr = 32'h204; htrans = 2'b11;
    tick();
    hwdata = 32'h2222_0004; haddr = 32'h208; htrans = 2'b01;
    tick();
    chk("t5_busy_ready", 32'(rdy), 32'd1);
    chk("t5_busy_resp", 32'(rsp), 32'd0);
    hwdata = 32'h0; haddr = 32'h208; htrans = 2'b11;
    tick();
    hwdata = 32'h3333_0008; haddr = 32'h20C; htrans = 2'b11;
    tick();
    chk("t5_beat4_ready", 32'(rdy), 32'd1);
    hwdata = 32'h4444_000C; htrans = 2'b00;
    tick();
    chk("t5_word0", u_d0.u_core.bd_read(32'h80), 32'h1111_0000);
    chk("t5_word1", u_d0.u_core.bd_read(32'h81), 32'h2222_0004);
    chk("t5_word2", u_d0.u_core.bd_read(32'h82), 32'h3333_0008);
    chk("t5_word3", u_d0.u_core.bd_read(32'h83), 32'h4444_000C);

    // reset in the middle of a waited write
    dsel = 2;
    xfer(1'b1, 32'h30, 3'd2, 32'h55AA_55AA);
    chk("t6_preload_lows", 32'(t_lows), 32'd5);
    hsel = 1'b1; hwrite = 1'b1; hsize = 3'd2; hburst = 3'd0; haddr = 32'h30; htrans = 2'b10;
    tick();
    htrans = 2'b00; hwdata = 32'h1234_5678;
    tick();
    tick();
    chk("t6_wait_ready", 32'(rdy), 32'd0);
    hreset = 1'b1;
    tick();
    chk("t6_rst_ready", 32'(rdy), 32'd1);
    chk("t6_rst_resp", 32'(rsp), 32'd0);
    chk("t6_rst_rdata", rdt, 32'd0);
    hreset = 1'b0;
    tick();
    chk("t6_mem_kept", u_d2.u_core.bd_read(32'hC), 32'h55AA_55AA);
    xfer(1'b0, 32'h30, 3'd2, 32'h0);
    chk("t6_read_data", t_rdata, 32'h55AA_55AA);
    chk("t6_read_lows", 32'(t_lows), 32'd5);
    chk("t6_other_mem", u_d0.u_core.bd_read(32'h4), 32'hA5A5_1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
